reg_writeback_queue: RTL and testbench
======================================

Name: reg_writeback_queue

Overview:
- Writer-side front end for the 32x32 register file.
- Accepts destination/result pairs from the ALU path and the load path, buffers them in a small in-order queue, and drains exactly one write per cycle onto the register file write port (RegWrite/writeReg/writeData).
- Publishes a pending-write mask so hazard logic can stall readers of registers with queued writes.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2
XLEN, 32, data width of results and register file
REG_AW, 5, register address width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
memValid  input  1  load result valid
memRd  input  REG_AW  load destination register
memData  input  XLEN  load result
memReady  output  1  load result accepted this cycle when memValid=1
aluValid  input  1  ALU result valid
aluRd  input  REG_AW  ALU destination register
aluData  input  XLEN  ALU result
aluReady  output  1  ALU result accepted this cycle when aluValid=1
flush  input  1  discard all queued, not-yet-issued writes
RegWrite  output  1  register file write enable (registered)
writeReg  output  REG_AW  register file write address (registered)
writeData  output  XLEN  register file write data (registered)
pendingMask  output  32  bit r=1 iff a queue entry targets register r
empty  output  1  queue has no entries and RegWrite=0

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset: count=0, read and write pointers=0, RegWrite=0, writeReg=0, writeData=0, pendingMask=0, empty=1.
- The queue occupancy count (0..DEPTH) is the only state; there is no other FSM.
- Pop:
  - If count>0 at an edge, the head entry loads into the output registers with RegWrite=1, and the pointer/count advance.
  - Otherwise RegWrite=0 for the next cycle; writeReg/writeData hold their last values.
- Latency: a result accepted at edge N with an empty queue drives RegWrite=1 during cycle N+1. The register file captures it combinationally in that cycle.
- Free-slot computation: free = DEPTH - count + (count>0 ? 1 : 0). Same-cycle pop frees a slot.
- Ready rules:
  - memReady = (free >= 1).
  - aluReady = (free >= (memValid ? 2 : 1)).
  - Neither ready depends on its own valid. Both readies are 0 during reset and while flush=1.
- Ordering:
  - Load results are older than ALU results.
  - When both are accepted in one cycle, the mem entry is enqueued first and the alu entry second. Both land in the same edge (two-entry push).
- x0 writes: a handshake with rd=0 completes (ready honoured) but nothing is enqueued. RegWrite is never asserted with writeReg=0.
- pendingMask:
  - OR of one-hot(rd) over valid queue entries only. The entry in the output register is already visible in the register file.
  - Bit 0 is constant 0.
  - Recomputed combinationally from registered queue state.
- Full: count==DEPTH with no pop is impossible while count>0, since a pop occurs every cycle. Therefore free>=1 always holds except when count==DEPTH... (free=1), so one push per cycle is always sustainable.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. count is a separate log2(DEPTH)+1-bit field.
- Flush:
  - At the edge where flush=1, count and pointers clear and RegWrite goes to 0.
  - Inputs presented in that cycle are not accepted.
  - A write already in the output register during the flush cycle still completes that cycle.
- Reset mid-operation: all queued writes are lost; no partial write is issued after the reset edge.

Optional Feature:
- Macro: REG_WRITEBACK_BYPASS_EN.
- With it defined:
  - Adds inputs fwdReg1 and fwdReg2 (REG_AW each).
  - Adds outputs fwdHit1/fwdHit2 (1 each) and fwdData1/fwdData2 (XLEN each).
  - Hit means the register matches the youngest valid queue entry with that rd; the data is that entry's data. Purely combinational.
  - fwdReg=0 never hits.
  - pendingMask is still produced.
- Without it: none of these ports exist; hazard logic relies on pendingMask stalls only.

Decomposition:
- Package wb_pkg: XLEN, REG_AW, NUM_REGS=32, and the typedef wb_entry_t {rd[REG_AW], data[XLEN]}.
- Sub-module wb_fifo:
  - DEPTH-entry circular buffer of wb_entry_t with a two-entry push and a single pop.
  - Exposes count and the flattened entries for mask/bypass logic.
- The top level holds the ready logic, x0 filtering, output registers and pendingMask.

Test Plan:
- Reset, then memValid=1, memRd=5, memData=0xDEADBEEF for one cycle -> memReady=1; next cycle RegWrite=1, writeReg=5, writeData=0xDEADBEEF; pendingMask[5]=1 only in the cycle between.
- Same cycle: mem(rd=3, 0x11) and alu(rd=3, 0x22) -> both ready; RegWrite pulses rd=3/0x11 then rd=3/0x22 on consecutive cycles.
- aluRd=0, aluData=0x1234 valid -> aluReady=1; RegWrite stays 0; pendingMask stays 0.
- Both sources valid every cycle for 10 cycles with DEPTH=4 -> queue saturates; memReady stays 1, aluReady drops; all accepted writes drain in mem-before-alu order with none lost or duplicated.
- Queue holding 3 entries, assert flush -> the output-register write completes that cycle; then RegWrite=0, empty=1, pendingMask=0 from the next cycle.
- With REG_WRITEBACK_BYPASS_EN: queue rd=7 with 0xA then 0xB, fwdReg1=7 -> fwdHit1=1, fwdData1=0xB; fwdReg2=0 -> fwdHit2=0.

Source files
------------

// File: rtl/reg_writeback_queue_pkg.sv
// Shared types and widths for the register-file writeback queue.
// Optional forwarding ports are enabled by REG_WRITEBACK_BYPASS_EN (see top).
package wb_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_queue_if.sv
// Bundle of producer handshakes, register-file write port and hazard outputs.
// Forwarding signals exist only when REG_WRITEBACK_BYPASS_EN is defined.
interface reg_writeback_queue_if;
  import wb_pkg::*;

  // Handshake: a result transfers on a cycle where its valid and ready are both 1
  // at the rising edge; ready never depends on the same source's valid.
  logic                memValid;
  logic [REG_AW-1:0]   memRd;
  logic [XLEN-1:0]     memData;
  logic                memReady;
  logic                aluValid;
  logic [REG_AW-1:0]   aluRd;
  logic [XLEN-1:0]     aluData;
  logic                aluReady;
  logic                flush;
  logic                RegWrite;
  logic [REG_AW-1:0]   writeReg;
  logic [XLEN-1:0]     writeData;
  logic [NUM_REGS-1:0] pendingMask;
  logic                empty;
`ifdef REG_WRITEBACK_BYPASS_EN
  logic [REG_AW-1:0]   fwdReg1;
  logic [REG_AW-1:0]   fwdReg2;
  logic                fwdHit1;
  logic                fwdHit2;
  logic [XLEN-1:0]     fwdData1;
  logic [XLEN-1:0]     fwdData2;

  modport master (output memValid, memRd, memData, aluValid, aluRd, aluData, flush,
                  fwdReg1, fwdReg2,
                  input  memReady, aluReady, RegWrite, writeReg, writeData, pendingMask,
                  empty, fwdHit1, fwdHit2, fwdData1, fwdData2);
  modport slave  (input  memValid, memRd, memData, aluValid, aluRd, aluData, flush,
                  fwdReg1, fwdReg2,
                  output memReady, aluReady, RegWrite, writeReg, writeData, pendingMask,
                  empty, fwdHit1, fwdHit2, fwdData1, fwdData2);
`else
  modport master (output memValid, memRd, memData, aluValid, aluRd, aluData, flush,
                  input  memReady, aluReady, RegWrite, writeReg, writeData, pendingMask,
                  empty);
  modport slave  (input  memValid, memRd, memData, aluValid, aluRd, aluData, flush,
                  output memReady, aluReady, RegWrite, writeReg, writeData, pendingMask,
                  empty);
`endif
endinterface

// File: rtl/reg_writeback_queue_fifo.sv
// In-order circular buffer with up to two pushes and one pop per cycle.
// Entries are presented oldest-first together with a per-slot valid flag.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [1:0]                 push_cnt,
  input  wb_entry_t                  push_e0,
  input  wb_entry_t                  push_e1,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output wb_entry_t [DEPTH-1:0]      entries,
  output logic [DEPTH-1:0]           entry_valid
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
  logic [CNT_W-1:0]      count_q, count_d;
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_cnt != 2'd0) mem_d[wr_ptr_q]   = push_e0;
      if (push_cnt == 2'd2) mem_d[wr_ptr_nxt] = push_e1;
      wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push_cnt) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Slot j of the view is the j-th oldest entry, so index 0 is the head.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      entries[j]     = mem_q[rd_ptr_q + PTR_W'(j)];
      entry_valid[j] = (CNT_W'(j) < count_q);
    end
  end

  assign count = count_q;
endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback front end: merges load/ALU results into an in-order queue draining one
// register-file write per cycle. Define REG_WRITEBACK_BYPASS_EN for forwarding ports.
module reg_writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_writeback_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]      count, free;
  wb_entry_t [DEPTH-1:0] q_entries;
  logic [DEPTH-1:0]      q_valid;
  logic                  pop, mem_ready, alu_ready, mem_push, alu_push;
  logic [1:0]            push_cnt;
  wb_entry_t             mem_e, alu_e, push_e0, push_e1;
  logic                  reg_write_q, reg_write_d;
  logic [REG_AW-1:0]     write_reg_q, write_reg_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;
  logic [NUM_REGS-1:0]   pending_mask;

  // The head pops every cycle the queue is non-empty, so that slot is free this cycle.
  always_comb begin
    free      = CNT_W'(DEPTH) - count + CNT_W'(count != '0);
    mem_ready = !reset && !bus.flush && (free >= CNT_W'(1));
    alu_ready = !reset && !bus.flush && (free >= (bus.memValid ? CNT_W'(2) : CNT_W'(1)));
    pop       = (count != '0) && !bus.flush;
    mem_push  = bus.memValid && mem_ready && (bus.memRd != '0);
    alu_push  = bus.aluValid && alu_ready && (bus.aluRd != '0);
    mem_e.rd   = bus.memRd;
    mem_e.data = bus.memData;
    alu_e.rd   = bus.aluRd;
    alu_e.data = bus.aluData;
    push_e0  = mem_push ? mem_e : alu_e;
    push_e1  = alu_e;
    push_cnt = 2'(mem_push) + 2'(alu_push);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush       (bus.flush),
    .push_cnt    (push_cnt),
    .push_e0     (push_e0),
    .push_e1     (push_e1),
    .pop         (pop),
    .count       (count),
    .entries     (q_entries),
    .entry_valid (q_valid)
  );

  always_comb begin
    reg_write_d  = pop;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (pop) begin
      write_reg_d  = q_entries[0].rd;
      write_data_d = q_entries[0].data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Only queued entries count; the output register is already visible downstream.
  always_comb begin
    pending_mask = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (q_valid[j]) pending_mask[q_entries[j].rd] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  assign bus.memReady    = mem_ready;
  assign bus.aluReady    = alu_ready;
  assign bus.RegWrite    = reg_write_q;
  assign bus.writeReg    = write_reg_q;
  assign bus.writeData   = write_data_q;
  assign bus.pendingMask = pending_mask;
  assign bus.empty       = (count == '0) && !reg_write_q;

`ifdef REG_WRITEBACK_BYPASS_EN
  // Scanning oldest to youngest lets the youngest matching entry win.
  always_comb begin
    bus.fwdHit1  = 1'b0;
    bus.fwdHit2  = 1'b0;
    bus.fwdData1 = '0;
    bus.fwdData2 = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (q_valid[j] && (bus.fwdReg1 != '0) && (q_entries[j].rd == bus.fwdReg1)) begin
        bus.fwdHit1  = 1'b1;
        bus.fwdData1 = q_entries[j].data;
      end
      if (q_valid[j] && (bus.fwdReg2 != '0) && (q_entries[j].rd == bus.fwdReg2)) begin
        bus.fwdHit2  = 1'b1;
        bus.fwdData2 = q_entries[j].data;
      end
    end
  end
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue (DEPTH=4) with immediate-assertion checks.
module tb_reg_writeback_queue;
  import wb_pkg::*;

  localparam int W = REG_AW + XLEN;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   drained = 0;
  logic [W-1:0] exp_q[$];
  logic [9:0]   alu_acc_exp;

  always #5 clk = ~clk;

  reg_writeback_queue_if bus();

  reg_writeback_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.memValid = 1'b0;
    bus.memRd    = '0;
    bus.memData  = '0;
    bus.aluValid = 1'b0;
    bus.aluRd    = '0;
    bus.aluData  = '0;
    bus.flush    = 1'b0;
`ifdef REG_WRITEBACK_BYPASS_EN
    bus.fwdReg1  = '0;
    bus.fwdReg2  = '0;
`endif
  endtask

  task automatic drive_mem(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
    bus.memValid = 1'b1;
    bus.memRd    = rd;
    bus.memData  = data;
  endtask

  task automatic drive_alu(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
    bus.aluValid = 1'b1;
    bus.aluRd    = rd;
    bus.aluData  = data;
  endtask

  // Every issued write must match the oldest outstanding expected write.
  task automatic check_drain();
    logic [W-1:0] exp;
    if (bus.RegWrite) begin
      drained++;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      chk($sformatf("drain_%0d", drained), 64'({bus.writeReg, bus.writeData}), 64'(exp));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    drive_mem(5'd9, 32'h9);
    drive_alu(5'd9, 32'h9);
    tick();
    tick();
    chk("rst_memReady", 64'(bus.memReady), 64'd0);
    chk("rst_aluReady", 64'(bus.aluReady), 64'd0);
    idle();
    reset = 1'b0;
    #1;
    chk("rst_RegWrite",    64'(bus.RegWrite),    64'd0);
    chk("rst_writeReg",    64'(bus.writeReg),    64'd0);
    chk("rst_writeData",   64'(bus.writeData),   64'd0);
    chk("rst_pendingMask", 64'(bus.pendingMask), 64'd0);
    chk("rst_empty",       64'(bus.empty),       64'd1);

    // Single load result
    drive_mem(5'd5, 32'hDEADBEEF);
    #1;
    chk("t1_memReady", 64'(bus.memReady), 64'd1);
    tick();
    idle();
    chk("t1_q_RegWrite", 64'(bus.RegWrite),    64'd0);
    chk("t1_q_mask",     64'(bus.pendingMask), 64'h20);
    chk("t1_q_empty",    64'(bus.empty),       64'd0);
    tick();
    chk("t1_RegWrite",  64'(bus.RegWrite),    64'd1);
    chk("t1_writeReg",  64'(bus.writeReg),    64'd5);
    chk("t1_writeData", 64'(bus.writeData),   64'hDEADBEEF);
    chk("t1_mask",      64'(bus.pendingMask), 64'd0);
    tick();
    chk("t1_idle_RegWrite", 64'(bus.RegWrite), 64'd0);
    chk("t1_idle_empty",    64'(bus.empty),    64'd1);
    chk("t1_hold_writeReg", 64'(bus.writeReg), 64'd5);

    // Load and ALU to the same register in one cycle: load first
    drive_mem(5'd3, 32'h11);
    drive_alu(5'd3, 32'h22);
    #1;
    chk("t2_memReady", 64'(bus.memReady), 64'd1);
    chk("t2_aluReady", 64'(bus.aluReady), 64'd1);
    tick();
    idle();
    chk("t2_mask0", 64'(bus.pendingMask), 64'h8);
    tick();
    chk("t2_w0_RegWrite", 64'(bus.RegWrite),    64'd1);
    chk("t2_w0_writeReg", 64'(bus.writeReg),    64'd3);
    chk("t2_w0_data",     64'(bus.writeData),   64'h11);
    chk("t2_mask1",       64'(bus.pendingMask), 64'h8);
    tick();
    chk("t2_w1_RegWrite", 64'(bus.RegWrite),    64'd1);
    chk("t2_w1_data",     64'(bus.writeData),   64'h22);
    chk("t2_mask2",       64'(bus.pendingMask), 64'd0);
    tick();
    chk("t2_idle_RegWrite", 64'(bus.RegWrite), 64'd0);

    // Write to x0 is accepted but dropped
    drive_alu(5'd0, 32'h1234);
    #1;
    chk("t3_aluReady", 64'(bus.aluReady), 64'd1);
    tick();
    idle();
    chk("t3_RegWrite", 64'(bus.RegWrite),    64'd0);
    chk("t3_mask",     64'(bus.pendingMask), 64'd0);
    chk("t3_empty",    64'(bus.empty),       64'd1);
    tick();
    chk("t3_RegWrite2", 64'(bus.RegWrite), 64'd0);

    // Saturation: free goes 4,3,2,1,1,... so the ALU is refused from the 4th cycle on
    alu_acc_exp = 10'b00_0000_0111;
    drained = 0;
    for (int k = 0; k < 10; k++) begin
      drive_mem(5'(k + 1), 32'(32'h100 + k));
      drive_alu(5'(k + 16), 32'(32'h200 + k));
      #1;
      chk($sformatf("t4_memReady_%0d", k), 64'(bus.memReady), 64'd1);
      chk($sformatf("t4_aluReady_%0d", k), 64'(bus.aluReady), 64'(alu_acc_exp[k]));
      exp_q.push_back({5'(k + 1), 32'(32'h100 + k)});
      if (alu_acc_exp[k]) exp_q.push_back({5'(k + 16), 32'(32'h200 + k)});
      tick();
      check_drain();
    end
    idle();
    for (int c = 0; c < 20; c++) begin
      tick();
      check_drain();
    end
    chk("t4_drained",   64'(drained),      64'd13);
    chk("t4_leftover",  64'(exp_q.size()), 64'd0);
    chk("t4_empty",     64'(bus.empty),    64'd1);

    // Flush with three queued entries and one write in the output register
    drive_mem(5'd10, 32'hA0);
    drive_alu(5'd11, 32'hB0);
    tick();
    drive_mem(5'd12, 32'hC0);
    drive_alu(5'd13, 32'hD0);
    #1;
    chk("t5_fill_aluReady", 64'(bus.aluReady), 64'd1);
    tick();
    idle();
    bus.flush = 1'b1;
    drive_mem(5'd14, 32'hE0);
    #1;
    chk("t5_memReady",   64'(bus.memReady),    64'd0);
    chk("t5_aluReady",   64'(bus.aluReady),    64'd0);
    chk("t5_RegWrite",   64'(bus.RegWrite),    64'd1);
    chk("t5_writeReg",   64'(bus.writeReg),    64'd10);
    chk("t5_writeData",  64'(bus.writeData),   64'hA0);
    chk("t5_mask",       64'(bus.pendingMask), 64'h3800);
    tick();
    idle();
    chk("t5_post_RegWrite", 64'(bus.RegWrite),    64'd0);
    chk("t5_post_empty",    64'(bus.empty),       64'd1);
    chk("t5_post_mask",     64'(bus.pendingMask), 64'd0);
    chk("t5_post_writeReg", 64'(bus.writeReg),    64'd10);
    tick();
    chk("t5_late_RegWrite", 64'(bus.RegWrite), 64'd0);
    chk("t5_late_empty",    64'(bus.empty),    64'd1);

    // Reset while a write is queued behind one in flight
    drive_mem(5'd20, 32'h2020);
    drive_alu(5'd21, 32'h2121);
    tick();
    idle();
    tick();
    chk("t6_pre_RegWrite", 64'(bus.RegWrite), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_RegWrite", 64'(bus.RegWrite),    64'd0);
    chk("t6_writeReg", 64'(bus.writeReg),    64'd0);
    chk("t6_mask",     64'(bus.pendingMask), 64'd0);
    chk("t6_empty",    64'(bus.empty),       64'd1);
    tick();
    chk("t6_late_RegWrite", 64'(bus.RegWrite), 64'd0);

`ifdef REG_WRITEBACK_BYPASS_EN
    // Forwarding returns the youngest entry for a register; x0 never hits
    drive_mem(5'd7, 32'hA);
    drive_alu(5'd7, 32'hB);
    tick();
    idle();
    bus.fwdReg1 = 5'd7;
    bus.fwdReg2 = 5'd0;
    #1;
    chk("t7_fwdHit1",  64'(bus.fwdHit1),     64'd1);
    chk("t7_fwdData1", 64'(bus.fwdData1),    64'hB);
    chk("t7_fwdHit2",  64'(bus.fwdHit2),     64'd0);
    chk("t7_mask",     64'(bus.pendingMask), 64'h80);
    tick();
    tick();
    tick();
    idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
